// File: rtl/sha1_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sha1_pkg
// Purpose  : SHA-1 constants, round helper functions and FSM state type.
// Revision : 1.0 - initial multi-block streaming release
// ============================================================================
package sha1_pkg;

    localparam logic [31:0] H0_INIT = 32'h67452301;
    localparam logic [31:0] H1_INIT = 32'hEFCDAB89;
    localparam logic [31:0] H2_INIT = 32'h98BADCFE;
    localparam logic [31:0] H3_INIT = 32'h10325476;
    localparam logic [31:0] H4_INIT = 32'hC3D2E1F0;
    localparam logic [159:0] IV_INIT = {H0_INIT, H1_INIT, H2_INIT, H3_INIT, H4_INIT};

    localparam logic [31:0] K0 = 32'h5A827999;
    localparam logic [31:0] K1 = 32'h6ED9EBA1;
    localparam logic [31:0] K2 = 32'h8F1BBCDC;
    localparam logic [31:0] K3 = 32'hCA62C1D6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FOLD  = 2'd2
    } sha1_state_t;

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
        return (x << n) | (x >> (6'd32 - {1'b0, n}));
    endfunction

    function automatic logic [31:0] sha1_f(input logic [6:0] t, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d);
        logic [31:0] f;
        if (t < 7'd20)      f = (b & c) | (~b & d);
        else if (t < 7'd40) f = b ^ c ^ d;
        else if (t < 7'd60) f = (b & c) | (b & d) | (c & d);
        else                f = b ^ c ^ d;
        return f;
    endfunction

    function automatic logic [31:0] sha1_k(input logic [6:0] t);
        logic [31:0] k;
        if (t < 7'd20)      k = K0;
        else if (t < 7'd40) k = K1;
        else if (t < 7'd60) k = K2;
        else                k = K3;
        return k;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha1_round.sv
`default_nettype none
// ============================================================================
// Module   : sha1_round
// Purpose  : One combinational SHA-1 round; chained UNROLL times by the top.
// Revision : 1.0 - initial multi-block streaming release
// ============================================================================
module sha1_round
    import sha1_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_c,
    input  logic [31:0] i_d,
    input  logic [31:0] i_e,
    input  logic [31:0] i_w,
    input  logic [6:0]  i_t,
    output logic [31:0] o_a,
    output logic [31:0] o_b,
    output logic [31:0] o_c,
    output logic [31:0] o_d,
    output logic [31:0] o_e
);

    logic [31:0] w_temp;

    assign w_temp = rotl(i_a, 5'd5) + sha1_f(i_t, i_b, i_c, i_d) + i_e + sha1_k(i_t) + i_w;

    assign o_a = w_temp;
    assign o_b = i_a;
    assign o_c = rotl(i_b, 5'd30);
    assign o_d = i_c;
    assign o_e = i_d;

endmodule
`default_nettype wire

// File: rtl/sha1_stream.sv
`default_nettype none
// ============================================================================
// Module   : sha1_stream
// Purpose  : Multi-block SHA-1 engine, UNROLL rounds per clock, chained H.
// Revision : 1.0 - initial multi-block streaming release
// ============================================================================
module sha1_stream
    import sha1_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic         blk_last,
    input  logic         abort,
    output logic [159:0] digest,
    output logic         digest_valid,
    output logic         busy,
    output logic [6:0]   round_idx
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
        $error("sha1_stream: UNROLL must be 1, 2 or 4");
    end

    localparam logic [6:0] c_last_round = 7'(80 - UNROLL);
    localparam logic [6:0] c_step       = 7'(UNROLL);

    sha1_state_t  r_state;
    logic [31:0]  r_h [0:4];
    logic [159:0] r_abcde;
    logic [31:0]  r_w [0:15];
    logic         r_last;
    logic [6:0]   r_round_idx;
    logic         r_digest_valid;
    logic         r_blk_ready;
    logic         r_busy;

    // Window always holds W[round_idx .. round_idx+15]; extend it by UNROLL words.
    logic [31:0]  w_ext [0:15+UNROLL];
    logic [159:0] w_next_abcde;

    always_comb begin
        for (int j = 0; j < 16; j++) begin
            w_ext[j] = r_w[j];
        end
        for (int j = 16; j < 16 + UNROLL; j++) begin
            w_ext[j] = rotl(w_ext[j-3] ^ w_ext[j-8] ^ w_ext[j-14] ^ w_ext[j-16], 5'd1);
        end
    end

    for (genvar k = 0; k < UNROLL; k++) begin : g_round
        logic [159:0] w_in;
        logic [159:0] w_out;

        if (k == 0) begin : g_first
            assign w_in = r_abcde;
        end else begin : g_chain
            assign w_in = g_round[k-1].w_out;
        end

        sha1_round u_round (
            .i_a (w_in[159:128]),
            .i_b (w_in[127:96]),
            .i_c (w_in[95:64]),
            .i_d (w_in[63:32]),
            .i_e (w_in[31:0]),
            .i_w (r_w[k]),
            .i_t (r_round_idx + 7'(k)),
            .o_a (w_out[159:128]),
            .o_b (w_out[127:96]),
            .o_c (w_out[95:64]),
            .o_d (w_out[63:32]),
            .o_e (w_out[31:0])
        );

        if (k == UNROLL - 1) begin : g_last
            assign w_next_abcde = w_out;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_abcde        <= '0;
            r_last         <= 1'b0;
            r_round_idx    <= '0;
            r_digest_valid <= 1'b0;
            r_blk_ready    <= 1'b1;
            r_busy         <= 1'b0;
            for (int i = 0; i < 5; i++)  r_h[i] <= IV_INIT[159-32*i -: 32];
            for (int i = 0; i < 16; i++) r_w[i] <= '0;
        end else if (abort) begin
            r_state        <= IDLE;
            r_round_idx    <= '0;
            r_digest_valid <= 1'b0;
            r_blk_ready    <= 1'b1;
            r_busy         <= 1'b0;
            for (int i = 0; i < 5; i++) r_h[i] <= IV_INIT[159-32*i -: 32];
        end else begin
            case (r_state)
                IDLE: begin
                    if (blk_valid) begin
                        if (blk_first) begin
                            for (int i = 0; i < 5; i++) r_h[i] <= IV_INIT[159-32*i -: 32];
                            r_abcde <= IV_INIT;
                        end else begin
                            r_abcde <= {r_h[0], r_h[1], r_h[2], r_h[3], r_h[4]};
                        end
                        for (int i = 0; i < 16; i++) r_w[i] <= blk_data[511-32*i -: 32];
                        r_last         <= blk_last;
                        r_round_idx    <= '0;
                        r_digest_valid <= 1'b0;
                        r_blk_ready    <= 1'b0;
                        r_busy         <= 1'b1;
                        r_state        <= ROUND;
                    end
                end
                ROUND: begin
                    r_abcde <= w_next_abcde;
                    for (int i = 0; i < 16; i++) r_w[i] <= w_ext[i+UNROLL];
                    r_round_idx <= r_round_idx + c_step;
                    if (r_round_idx == c_last_round) begin
                        r_state <= FOLD;
                    end
                end
                FOLD: begin
                    for (int i = 0; i < 5; i++) r_h[i] <= r_h[i] + r_abcde[159-32*i -: 32];
                    if (r_last) begin
                        r_digest_valid <= 1'b1;
                    end
                    r_round_idx <= '0;
                    r_blk_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state     <= IDLE;
                    r_blk_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign blk_ready    = r_blk_ready;
    assign busy         = r_busy;
    assign digest       = {r_h[0], r_h[1], r_h[2], r_h[3], r_h[4]};
    assign digest_valid = r_digest_valid;
    assign round_idx    = r_round_idx;

endmodule
`default_nettype wire

// File: tb/tb_sha1_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha1_stream
// Purpose  : Self-checking bench for sha1_stream against a software SHA-1.
// Revision : 1.0 - initial multi-block streaming release
// ============================================================================
module tb_sha1_stream;

    localparam int UNROLL = 1;
    localparam int LAT    = 80 / UNROLL + 1;
    localparam logic [159:0] IV = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;

    logic         clk;
    logic         reset_n;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;
    logic         abort;
    logic [159:0] digest;
    logic         digest_valid;
    logic         busy;
    logic [6:0]   round_idx;

    sha1_stream #(.UNROLL(UNROLL)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .blk_valid    (blk_valid),
        .blk_ready    (blk_ready),
        .blk_data     (blk_data),
        .blk_first    (blk_first),
        .blk_last     (blk_last),
        .abort        (abort),
        .digest       (digest),
        .digest_valid (digest_valid),
        .busy         (busy),
        .round_idx    (round_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [159:0] model_h;

    task automatic check_val(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Textbook SHA-1 compression of one 512-bit block.
    function automatic logic [159:0] ref_compress(input logic [159:0] hin, input logic [511:0] blk);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, tmp;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 80; i++) w[i] = rl(w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16], 1);
        {a, b, c, d, e} = hin;
        for (int i = 0; i < 80; i++) begin
            case (i / 20)
                0:       begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
                1:       begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
                2:       begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
                default: begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
            endcase
            tmp = rl(a, 5) + f + e + k + w[i];
            e = d; d = c; c = rl(b, 30); b = a; a = tmp;
        end
        return {hin[159:128] + a, hin[127:96] + b, hin[95:64] + c, hin[63:32] + d, hin[31:0] + e};
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic offer(input logic [511:0] d, input logic f, input logic l);
        int n;
        blk_data  = d;
        blk_first = f;
        blk_last  = l;
        blk_valid = 1'b1;
        n = 0;
        while (!blk_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check_val("ready_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        blk_valid = 1'b0;
        blk_data  = rand_block();
        blk_first = 1'($urandom);
        blk_last  = 1'($urandom);
        if (f) model_h = IV;
        model_h = ref_compress(model_h, d);
        check_val("accept_ready_low", {159'd0, blk_ready}, 0);
        check_val("accept_dv_clear", {159'd0, digest_valid}, 0);
        check_val("accept_busy", {159'd0, busy}, 1);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!blk_ready && cyc < 400);
    endtask

    task automatic run_block(input string tag, input logic [511:0] d, input logic f, input logic l);
        int cyc;
        offer(d, f, l);
        wait_done(cyc);
        check_val({tag, "_latency"}, 160'(cyc), 160'(LAT));
        check_val({tag, "_digest"}, digest, model_h);
        check_val({tag, "_dv"}, {159'd0, digest_valid}, {159'd0, l});
    endtask

    logic [511:0] blk_abc, blk_empty, blk_two1, blk_two2;

    initial begin
        int seen_dv;
        int n;
        blk_abc   = {32'h61626380, 448'h0, 32'h00000018};
        blk_empty = {32'h80000000, 480'h0};
        blk_two1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        blk_two2  = {480'h0, 32'h000001c0};

        reset_n   = 1'b0;
        abort     = 1'b0;
        blk_valid = 1'b0;
        blk_data  = '0;
        blk_first = 1'b0;
        blk_last  = 1'b0;
        model_h   = IV;
        #12;
        check_val("rst_digest", digest, IV);
        check_val("rst_dv", {159'd0, digest_valid}, 0);
        check_val("rst_ready", {159'd0, blk_ready}, 1);
        check_val("rst_busy", {159'd0, busy}, 0);
        check_val("rst_round_idx", {153'd0, round_idx}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_block("abc", blk_abc, 1'b1, 1'b1);
        check_val("abc_kat", digest, 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d);

        run_block("empty", blk_empty, 1'b1, 1'b1);
        check_val("empty_kat", digest, 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709);

        run_block("two_b1", blk_two1, 1'b1, 1'b0);
        run_block("two_b2", blk_two2, 1'b0, 1'b1);
        check_val("two_kat", digest, 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1);

        // A block offered together with abort must be refused.
        blk_valid = 1'b1;
        blk_data  = blk_abc;
        blk_first = 1'b1;
        abort     = 1'b1;
        @(negedge clk);
        blk_valid = 1'b0;
        abort     = 1'b0;
        model_h   = IV;
        check_val("abort_refuse_ready", {159'd0, blk_ready}, 1);
        check_val("abort_refuse_busy", {159'd0, busy}, 0);
        check_val("abort_idle_digest", digest, IV);

        offer(blk_two1, 1'b1, 1'b0);
        seen_dv = 0;
        n = 0;
        while (round_idx < 7'd37 && n < 200) begin
            if (digest_valid) seen_dv = 1;
            @(negedge clk);
            n++;
        end
        check_val("abort_reach_r37", {159'd0, (n < 200)}, 1);
        abort = 1'b1;
        @(negedge clk);
        abort   = 1'b0;
        model_h = IV;
        check_val("abort_ready", {159'd0, blk_ready}, 1);
        check_val("abort_busy", {159'd0, busy}, 0);
        check_val("abort_round_idx", {153'd0, round_idx}, 0);
        check_val("abort_digest", digest, IV);
        check_val("abort_no_dv", 160'(seen_dv), 0);
        run_block("post_abort", blk_abc, 1'b0, 1'b1);
        check_val("post_abort_kat", digest, 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d);

        // Asynchronous reset between clock edges, mid-ROUND.
        offer(blk_two1, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_val("arst_digest", digest, IV);
        check_val("arst_dv", {159'd0, digest_valid}, 0);
        check_val("arst_ready", {159'd0, blk_ready}, 1);
        check_val("arst_busy", {159'd0, busy}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_h = IV;
        @(negedge clk);
        run_block("post_arst", blk_abc, 1'b0, 1'b1);
        check_val("post_arst_kat", digest, 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d);

        // Random multi-block messages, occasionally chaining without blk_first.
        for (int m = 0; m < 12; m++) begin
            int nblk;
            nblk = int'($urandom_range(1, 3));
            for (int b = 0; b < nblk; b++) begin
                logic f;
                f = (b == 0) ? ($urandom_range(0, 3) != 0) : 1'b0;
                run_block($sformatf("rnd_m%0d_b%0d", m, b), rand_block(), f, (b == nblk - 1));
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sha1_stream.md
# sha1_stream

Parametrised multi-block SHA-1 compression engine. Accepts pre-padded 512-bit blocks over a valid/ready handshake and chains the hash state across the blocks of one message. Produces the 160-bit digest after the last block. Rounds per clock are selectable at elaboration. Sits between the message padder/buffer and any consumer of `digest`; supersedes the single-block `sha1` core.

## Interface
- `UNROLL`, default 1: SHA-1 rounds executed per clock. Legal values are 1, 2 and 4; any other value must fail elaboration.

- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `blk_valid`  in  1  `blk_data`, `blk_first` and `blk_last` are valid
- `blk_ready`  out  1  engine can accept a block; reset value 1
- `blk_data`  in  512  padded block; W0 = [511:480], W15 = [31:0], big-endian words
- `blk_first`  in  1  first block of a message: chain state restarts from the IV
- `blk_last`  in  1  last block of a message: digest is published after it
- `abort`  in  1  synchronous cancel; highest priority below reset
- `digest`  out  160  {H0,H1,H2,H3,H4}; reset value is the IV, 67452301 EFCDAB89 98BADCFE 10325476 C3D2E1F0
- `digest_valid`  out  1  `digest` holds a complete message hash; reset value 0
- `busy`  out  1  high in ROUND or FOLD; reset value 0
- `round_idx`  out  7  index of the next round to execute, 0..79; reset value 0

## Operation
- FSM states are IDLE, ROUND and FOLD. Reset enters IDLE.
- IDLE:
  - `blk_ready`=1.
  - On an edge with `blk_valid`&&`blk_ready`:
    - if `blk_first`, H<=IV and a..e<=IV; otherwise a..e<=H;
    - the W window (16×32 shift register) <= `blk_data`;
    - `last_q`<=`blk_last`; `round_idx`<=0; `digest_valid`<=0; go to ROUND.
- ROUND:
  - Each edge applies UNROLL chained rounds t = `round_idx` .. `round_idx`+UNROLL-1.
  - Round function:
    - temp = rotl5(a) + f_t(b,c,d) + e + K_t + W_t, all mod 2^32;
    - e<=d; d<=c; c<=rotl30(b); b<=a; a<=temp.
  - f_t and K_t by range:
    - 0–19: Ch, 5A827999;
    - 20–39: Parity, 6ED9EBA1;
    - 40–59: Maj, 8F1BBCDC;
    - 60–79: Parity, CA62C1D6.
  - Message schedule:
    - W_t = window[0] for t<16; otherwise rotl1(W_{t-3}^W_{t-8}^W_{t-14}^W_{t-16}), computed from the window;
    - the window shifts by UNROLL words per edge.
  - `round_idx` += UNROLL. When `round_idx`+UNROLL==80, go to FOLD.
- FOLD (one edge):
  - H_i <= H_i + {a,b,c,d,e}_i mod 2^32.
  - If `last_q`, `digest_valid`<=1.
  - `round_idx`<=0; go to IDLE.
- `digest_valid` stays high and `digest` stays stable until the next accepted block or `abort`.
- A non-first block continues from the current H. After reset or abort that is the IV, so such a block behaves as first.
- `abort` in any state: go to IDLE next edge; H<=IV, `digest_valid`<=0, `round_idx`<=0. A block offered with `abort` high is not accepted.
- Input stability: `blk_data`, `blk_first` and `blk_last` are sampled only on the accept edge. Changes while `busy` are ignored.

## Timing
- Accept edge = E0. Rounds occur on E1..E(80/UNROLL). FOLD is E(80/UNROLL+1).
- `blk_ready` is low from E0 to E(80/UNROLL+1) and returns high after the FOLD edge.
- Digest latency from the accept edge: 81 / 41 / 21 cycles for UNROLL 1 / 2 / 4.
- Block throughput: one block per 80/UNROLL+2 cycles.
- `blk_ready` is a registered state decode with no combinational path from `blk_valid`.
- Reset assertion mid-block: all outputs take their reset values immediately (asynchronous); the partial block is discarded.

## Structure
- Package `sha1_pkg` holds:
  - IV constants H0_INIT..H4_INIT and K constants K0..K3;
  - functions `rotl`, `sha1_f(t,b,c,d)` and `sha1_k(t)`;
  - the state typedef `sha1_state_t` {IDLE, ROUND, FOLD}.
- Sub-module `sha1_round`: purely combinational single round. Inputs are a..e, W and t; outputs are next a..e. Instantiated UNROLL times in a chain.
- Top holds the FSM, counter, W window and H registers.

## Test plan
- "abc" single block (61626380, 13 zero words, 00000018; first=last=1) -> digest a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d. Check latency 81/41/21 for UNROLL 1/2/4.
- Empty message (80000000 followed by zeros) -> da39a3ee 5e6b4b0d 3255bfef 95601890 afd80709.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (448 bits) with first, then last, presented back-to-back -> 84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1. Check `digest_valid` stays 0 after block 1.
- Two messages with no idle gap: "abc" then the empty message -> second digest is correct (chain restarted by `blk_first`). `digest_valid` drops on the second accept edge.
- `abort` at round 37 of block 1 of the two-block message, then "abc" -> "abc" digest is correct; no `digest_valid` pulse for the aborted message.
- `reset_n` pulsed low mid-ROUND (asynchronous, between edges) -> `digest`=IV, `digest_valid`=0, `blk_ready`=1 without waiting for a clock edge; a subsequent "abc" gives the correct digest.
